// File: rtl/r16_bu_sched_pkg.sv
// rtl/r16_bu_sched_pkg.sv - shared types and constants for the radix-16 BU scheduler
package r16_bu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SDRAIN = 2'd2,
        FIN    = 2'd3
    } sched_state_e;

    localparam int DEF_GRP_W   = 10;
    localparam int GRP_NUM     = 1 << DEF_GRP_W;
    localparam int DEF_STG_NUM = 4;
    localparam int DEF_STG_W   = 2;
    localparam int DEF_BU_LAT  = 6;

    // Width of one in-flight entry: {valid, grp, stg}
    function automatic int pipe_w(input int grp_w, input int stg_w);
        return 1 + grp_w + stg_w;
    endfunction

endpackage

// File: rtl/r16_vld_pipe.sv
// rtl/r16_vld_pipe.sv - in-flight tracking shift register with valid-OR for the drain check
module r16_vld_pipe
    import r16_bu_sched_pkg::*;
#(
    parameter int DEPTH = DEF_BU_LAT,
    parameter int W     = pipe_w(DEF_GRP_W, DEF_STG_W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic         o_any_vld
);

    logic [W-1:0] r_sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[DEPTH-1];

    // The valid flag sits in the MSB of every entry
    always_comb begin
        o_any_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            o_any_vld = o_any_vld | r_sr[i][W-1];
        end
    end

endmodule

// File: rtl/r16_bu_sched.sv
// rtl/r16_bu_sched.sv - stage/group issue and retire scheduler for the radix-16 butterfly unit
module r16_bu_sched
    import r16_bu_sched_pkg::*;
#(
    parameter int STG_NUM = DEF_STG_NUM,
    parameter int GRP_W   = $clog2(GRP_NUM),
    parameter int STG_W   = DEF_STG_W,
    parameter int BU_LAT  = DEF_BU_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hold,
    output logic             rd_en,
    output logic [GRP_W-1:0] rd_grp,
    output logic [STG_W-1:0] rd_stg,
    output logic             wr_en,
    output logic [GRP_W-1:0] wr_grp,
    output logic [STG_W-1:0] wr_stg,
    output logic             br_en,
    output logic             busy,
    output logic             done
);

    localparam int PW = pipe_w(GRP_W, STG_W);

    sched_state_e     r_state;
    sched_state_e     w_next;
    logic [GRP_W-1:0] r_grp;
    logic [STG_W-1:0] r_stg;
    logic             r_br;
    logic             w_last_grp;
    logic             w_last_stg;
    logic             w_drained;
    logic             w_pipe_any;
    logic [PW-1:0]    w_pipe_in;
    logic [PW-1:0]    w_pipe_out;

    assign w_last_grp = (r_grp == {GRP_W{1'b1}});
    assign w_last_stg = (r_stg == STG_W'(STG_NUM - 1));
    // In-place memory: next stage may not read until the BR stage has also retired
    assign w_drained  = !w_pipe_any && !r_br;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (!hold && w_last_grp) w_next = SDRAIN;
            SDRAIN:  if (w_drained) w_next = w_last_stg ? FIN : RUN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (r_state)
            RUN: begin
                rd_en = !hold;
                busy  = 1'b1;
            end
            SDRAIN:  busy = 1'b1;
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Group saturates on the last issue; only the stage advance resets it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grp <= '0;
            r_stg <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_grp <= '0;
                        r_stg <= '0;
                    end
                end
                RUN: begin
                    if (!hold && !w_last_grp) r_grp <= r_grp + 1'b1;
                end
                SDRAIN: begin
                    if (w_drained && !w_last_stg) begin
                        r_grp <= '0;
                        r_stg <= r_stg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_grp    = r_grp;
    assign rd_stg    = r_stg;
    assign w_pipe_in = {rd_en, r_grp, r_stg};

    r16_vld_pipe #(
        .DEPTH (BU_LAT),
        .W     (PW)
    ) u_vld_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_d       (w_pipe_in),
        .o_q       (w_pipe_out),
        .o_any_vld (w_pipe_any)
    );

    assign {wr_en, wr_grp, wr_stg} = w_pipe_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br <= 1'b0;
        end else begin
            r_br <= wr_en;
        end
    end

    assign br_en = r_br;

endmodule
